// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler: a three-slot write scoreboard (EX/MEM/WB) interlocks RAW
// dependences and holds the pipeline while a multi-cycle multiply is in EX.
module hazard_scheduler #(
    parameter int TIMEOUT = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic        dec_rt_used,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rf_wp,
    input  logic        dec_multi,
    input  logic        alu_done,
    output logic        stall,
    output logic        bubble,
    output logic        ex_hold,
    output logic        issued,
    output logic        timeout_err,
    output logic [15:0] stall_count
);
    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } stateT;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    stateT       stateReg, stateNext;
    logic [7:0]  waitReg, waitNext;
    logic        timeoutErrReg, timeoutErrNext;
    logic [15:0] stallCountReg;

    // Slot 0 = EX, 1 = MEM, 2 = WB; a slot is only marked valid for a real write to r1..r31.
    logic [2:0]  slotValidReg, slotValidNext;
    logic [4:0]  slotRdReg  [3];
    logic [4:0]  slotRdNext [3];

    logic [2:0]  slotHit;
    logic        hazard;
    logic        stallComb, bubbleComb, exHoldComb, issuedComb;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : gSlotHit
        assign slotHit[gi] = slotValidReg[gi] &&
                             ((slotRdReg[gi] == dec_rs) ||
                              (dec_rt_used && (slotRdReg[gi] == dec_rt)));
    end

    assign hazard = dec_valid && (|slotHit);

    always_comb begin
        stateNext      = stateReg;
        waitNext       = waitReg;
        timeoutErrNext = timeoutErrReg;
        stallComb      = 1'b0;
        bubbleComb     = 1'b0;
        exHoldComb     = 1'b0;
        issuedComb     = 1'b0;
        slotValidNext  = {slotValidReg[1:0], 1'b0};
        slotRdNext[0]  = '0;
        slotRdNext[1]  = slotRdReg[0];
        slotRdNext[2]  = slotRdReg[1];

        case (stateReg)
            RUN: begin
                issuedComb = dec_valid && !hazard;
                stallComb  = dec_valid && hazard;
                bubbleComb = dec_valid && hazard;
                if (issuedComb) begin
                    slotValidNext[0] = dec_rf_wp && (dec_rd != 5'd0);
                    slotRdNext[0]    = dec_rd;
                    if (dec_multi) begin
                        stateNext = MUL_WAIT;
                        waitNext  = '0;
                    end
                end
            end
            MUL_WAIT: begin
                stallComb  = 1'b1;
                exHoldComb = !alu_done;
                if (alu_done) begin
                    stateNext = RUN;
                end else if (waitReg == WAIT_LAST) begin
                    // Forced exit drains the multiply exactly like a normal completion.
                    stateNext      = RUN;
                    timeoutErrNext = 1'b1;
                end else begin
                    waitNext         = waitReg + 8'd1;
                    slotValidNext[0] = slotValidReg[0];
                    slotRdNext[0]    = slotRdReg[0];
                    slotValidNext[1] = 1'b0;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg      <= RUN;
            waitReg       <= '0;
            timeoutErrReg <= 1'b0;
            stallCountReg <= '0;
            slotValidReg  <= '0;
            for (int i = 0; i < 3; i++) begin
                slotRdReg[i] <= '0;
            end
        end else begin
            stateReg      <= stateNext;
            waitReg       <= waitNext;
            timeoutErrReg <= timeoutErrNext;
            slotValidReg  <= slotValidNext;
            for (int i = 0; i < 3; i++) begin
                slotRdReg[i] <= slotRdNext[i];
            end
            if (stallComb && (stallCountReg != 16'hFFFF)) begin
                stallCountReg <= stallCountReg + 16'd1;
            end
        end
    end

    // Control strobes are forced low for as long as reset is held.
    assign stall       = reset && stallComb;
    assign bubble      = reset && bubbleComb;
    assign ex_hold     = reset && exHoldComb;
    assign issued      = reset && issuedComb;
    assign timeout_err = timeoutErrReg;
    assign stall_count = stallCountReg;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: two instances (TIMEOUT 32 and 4) share stimulus and are checked
// against a pipeline-list reference model, a hand-derived vector table and directed sequences.
module tb_hazard_scheduler;
    logic        clock = 1'b0;
    logic        rstN, decValid, decRtUsed, decRfWp, decMulti, aluDone;
    logic [4:0]  decRs, decRt, decRd;
    logic        stallA, bubbleA, exHoldA, issuedA, errA;
    logic        stallB, bubbleB, exHoldB, issuedB, errB;
    logic [15:0] scA, scB;

    always #5 clock = ~clock;

    hazard_scheduler #(.TIMEOUT(32)) dut (
        .clock(clock), .reset(rstN), .dec_valid(decValid), .dec_rs(decRs), .dec_rt(decRt),
        .dec_rt_used(decRtUsed), .dec_rd(decRd), .dec_rf_wp(decRfWp), .dec_multi(decMulti),
        .alu_done(aluDone), .stall(stallA), .bubble(bubbleA), .ex_hold(exHoldA),
        .issued(issuedA), .timeout_err(errA), .stall_count(scA)
    );

    hazard_scheduler #(.TIMEOUT(4)) dut4 (
        .clock(clock), .reset(rstN), .dec_valid(decValid), .dec_rs(decRs), .dec_rt(decRt),
        .dec_rt_used(decRtUsed), .dec_rd(decRd), .dec_rf_wp(decRfWp), .dec_multi(decMulti),
        .alu_done(aluDone), .stall(stallB), .bubble(bubbleB), .ex_hold(exHoldB),
        .issued(issuedB), .timeout_err(errB), .stall_count(scB)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: each instance keeps the registers written by the three instructions
    // in flight (0 = nothing to write), youngest first, plus multiply-wait bookkeeping.
    int lim [2] = '{32, 4};
    bit mWait [2];
    int mSpent [2];
    bit mErr [2];
    int mSc [2];
    int pipe [2][3];
    bit eStall [2], eBubble [2], eHold [2], eIssued [2];

    function automatic bit inPipe(input int k, input int r);
        return (r != 0) && (pipe[k][0] == r || pipe[k][1] == r || pipe[k][2] == r);
    endfunction

    task automatic modelEval();
        for (int k = 0; k < 2; k++) begin
            bit haz;
            eStall[k] = 0; eBubble[k] = 0; eHold[k] = 0; eIssued[k] = 0;
            if (rstN) begin
                if (!mWait[k]) begin
                    haz = decValid && (inPipe(k, int'(decRs)) || (decRtUsed && inPipe(k, int'(decRt))));
                    eIssued[k] = decValid && !haz;
                    eStall[k]  = decValid && haz;
                    eBubble[k] = decValid && haz;
                end else begin
                    eStall[k] = 1;
                    eHold[k]  = !aluDone;
                end
            end
        end
    endtask

    task automatic modelAdvance();
        for (int k = 0; k < 2; k++) begin
            if (!rstN) begin
                mWait[k] = 0; mSpent[k] = 0; mErr[k] = 0; mSc[k] = 0;
                for (int j = 0; j < 3; j++) pipe[k][j] = 0;
            end else begin
                if (eStall[k] && mSc[k] < 65535) mSc[k]++;
                if (!mWait[k]) begin
                    pipe[k][2] = pipe[k][1];
                    pipe[k][1] = pipe[k][0];
                    pipe[k][0] = (eIssued[k] && decRfWp) ? int'(decRd) : 0;
                    if (eIssued[k] && decMulti) begin
                        mWait[k] = 1;
                        mSpent[k] = 0;
                    end
                end else if (aluDone || (mSpent[k] + 1 >= lim[k])) begin
                    if (!aluDone) mErr[k] = 1;
                    mWait[k] = 0;
                    pipe[k][2] = pipe[k][1];
                    pipe[k][1] = pipe[k][0];
                    pipe[k][0] = 0;
                end else begin
                    // Multiply stays in EX; a hole opens behind it in MEM.
                    mSpent[k]++;
                    pipe[k][2] = pipe[k][1];
                    pipe[k][1] = 0;
                end
            end
        end
    endtask

    task automatic cmpInst(input string tag, input int k, input logic s, input logic b,
                           input logic h, input logic i, input logic e, input logic [15:0] sc);
        check({tag, ".stall"},       int'(s),  int'(eStall[k]));
        check({tag, ".bubble"},      int'(b),  int'(eBubble[k]));
        check({tag, ".ex_hold"},     int'(h),  int'(eHold[k]));
        check({tag, ".issued"},      int'(i),  int'(eIssued[k]));
        check({tag, ".timeout_err"}, int'(e),  int'(mErr[k]));
        check({tag, ".stall_count"}, int'(sc), mSc[k]);
    endtask

    task automatic settle();
        #1;
        modelEval();
        cmpInst("t32", 0, stallA, bubbleA, exHoldA, issuedA, errA, scA);
        cmpInst("t4",  1, stallB, bubbleB, exHoldB, issuedB, errB, scB);
    endtask

    task automatic advance();
        @(posedge clock);
        modelAdvance();
        @(negedge clock);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic setIn(input bit r, input bit v, input int rs, input int rt, input bit u,
                         input int rd, input bit wp, input bit mu, input bit dn);
        rstN = r; decValid = v; decRs = 5'(rs); decRt = 5'(rt); decRtUsed = u;
        decRd = 5'(rd); decRfWp = wp; decMulti = mu; aluDone = dn;
    endtask

    typedef struct {
        bit v; int rs; int rt; bit u; int rd; bit wp; bit mu; bit dn;
        bit xs; bit xb; bit xi; int xsc;
    } vecT;

    function automatic vecT mk(input bit v, input int rs, input int rt, input bit u, input int rd,
                               input bit wp, input bit mu, input bit dn,
                               input bit xs, input bit xb, input bit xi, input int xsc);
        vecT t;
        t.v = v; t.rs = rs; t.rt = rt; t.u = u; t.rd = rd; t.wp = wp; t.mu = mu; t.dn = dn;
        t.xs = xs; t.xb = xb; t.xi = xi; t.xsc = xsc;
        return t;
    endfunction

    vecT vecs [$];

    initial begin
        // Back-to-back RAW on rs: three stall/bubble cycles, then issue.
        vecs.push_back(mk(1,  1,  2, 1,  3, 1, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(1,  3,  0, 0,  4, 1, 0, 0,  1, 1, 0, 0));
        vecs.push_back(mk(1,  3,  0, 0,  4, 1, 0, 0,  1, 1, 0, 1));
        vecs.push_back(mk(1,  3,  0, 0,  4, 1, 0, 0,  1, 1, 0, 2));
        vecs.push_back(mk(1,  3,  0, 0,  4, 1, 0, 0,  0, 0, 1, 3));
        // Distance 2 on rt with rt used: two stalls.
        vecs.push_back(mk(1, 10, 11, 1,  5, 1, 0, 0,  0, 0, 1, 3));
        vecs.push_back(mk(1, 12, 13, 1,  6, 1, 0, 0,  0, 0, 1, 3));
        vecs.push_back(mk(1, 14,  5, 1,  7, 1, 0, 0,  1, 1, 0, 3));
        vecs.push_back(mk(1, 14,  5, 1,  7, 1, 0, 0,  1, 1, 0, 4));
        vecs.push_back(mk(1, 14,  5, 1,  7, 1, 0, 0,  0, 0, 1, 5));
        // Same distance with rt unused: no stall.
        vecs.push_back(mk(1, 10, 11, 1,  5, 1, 0, 0,  0, 0, 1, 5));
        vecs.push_back(mk(1, 12, 13, 1,  6, 1, 0, 0,  0, 0, 1, 5));
        vecs.push_back(mk(1, 14,  5, 0,  7, 1, 0, 0,  0, 0, 1, 5));
        // Writer of r0 never blocks a reader of r0.
        vecs.push_back(mk(1, 15, 16, 1,  0, 1, 0, 0,  0, 0, 1, 5));
        vecs.push_back(mk(1,  0,  0, 1,  8, 1, 0, 0,  0, 0, 1, 5));
        // Idle decode never stalls even with a matching rs; then distance-2 consumer.
        vecs.push_back(mk(0,  8,  8, 1,  0, 0, 0, 0,  0, 0, 0, 5));
        vecs.push_back(mk(1,  8,  1, 0,  0, 0, 0, 0,  1, 1, 0, 5));
        vecs.push_back(mk(1,  8,  1, 0,  0, 0, 0, 0,  1, 1, 0, 6));
        vecs.push_back(mk(1,  8,  1, 0,  0, 0, 0, 0,  0, 0, 1, 7));
        // Non-writing producer, and alu_done in RUN is ignored.
        vecs.push_back(mk(1, 17, 18, 1,  9, 0, 0, 1,  0, 0, 1, 7));
        vecs.push_back(mk(1,  9,  9, 1,  0, 0, 0, 0,  0, 0, 1, 7));
        // Distance 3 stalls once; distance 4 is clear.
        vecs.push_back(mk(1,  1,  2, 0, 20, 1, 0, 0,  0, 0, 1, 7));
        vecs.push_back(mk(1,  1,  2, 0, 21, 1, 0, 0,  0, 0, 1, 7));
        vecs.push_back(mk(1,  1,  2, 0, 22, 1, 0, 0,  0, 0, 1, 7));
        vecs.push_back(mk(1, 20,  2, 0, 23, 1, 0, 0,  1, 1, 0, 7));
        vecs.push_back(mk(1, 20,  2, 0, 23, 1, 0, 0,  0, 0, 1, 8));
        vecs.push_back(mk(1, 21,  2, 0, 24, 1, 0, 0,  0, 0, 1, 8));

        for (int k = 0; k < 2; k++) begin
            mWait[k] = 0; mSpent[k] = 0; mErr[k] = 0; mSc[k] = 0;
            for (int j = 0; j < 3; j++) pipe[k][j] = 0;
        end

        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        advance();
        advance();

        foreach (vecs[n]) begin
            setIn(1, vecs[n].v, vecs[n].rs, vecs[n].rt, vecs[n].u, vecs[n].rd,
                  vecs[n].wp, vecs[n].mu, vecs[n].dn);
            settle();
            check($sformatf("vec%0d.stall", n),       int'(stallA),  int'(vecs[n].xs));
            check($sformatf("vec%0d.bubble", n),      int'(bubbleA), int'(vecs[n].xb));
            check($sformatf("vec%0d.issued", n),      int'(issuedA), int'(vecs[n].xi));
            check($sformatf("vec%0d.ex_hold", n),     int'(exHoldA), 0);
            check($sformatf("vec%0d.stall_count", n), int'(scA),     vecs[n].xsc);
            advance();
        end

        // Multiply finishing in its 6th wait cycle, with a dependent op waiting in decode.
        for (int n = 0; n < 3; n++) begin
            setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        setIn(1, 1, 1, 2, 0, 12, 1, 1, 0);
        settle();
        check("mul.issue", int'(issuedA), 1);
        advance();
        for (int n = 1; n <= 6; n++) begin
            setIn(1, 1, 12, 0, 0, 13, 1, 0, n == 6);
            settle();
            check($sformatf("mul.w%0d.stall", n),   int'(stallA),  1);
            check($sformatf("mul.w%0d.ex_hold", n), int'(exHoldA), (n < 6) ? 1 : 0);
            check($sformatf("mul.w%0d.bubble", n),  int'(bubbleA), 0);
            check($sformatf("mul.w%0d.issued", n),  int'(issuedA), 0);
            advance();
        end
        setIn(1, 1, 12, 0, 0, 13, 1, 0, 0);
        settle();
        check("mul.dep_mem.bubble", int'(bubbleA), 1);
        advance();
        settle();
        check("mul.dep_wb.stall", int'(stallA), 1);
        advance();
        settle();
        check("mul.dep.issued", int'(issuedA), 1);
        check("mul.timeout_err", int'(errA), 0);
        check("mul.stall_count", int'(scA), 16);
        advance();

        // Reset held two cycles in the middle of a multiply wait.
        setIn(1, 1, 1, 2, 0, 14, 1, 1, 0);
        settle();
        check("rst.mul_issue", int'(issuedA), 1);
        advance();
        for (int n = 0; n < 2; n++) begin
            setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            check("rst.in_wait", int'(stallA), 1);
            advance();
        end
        for (int n = 0; n < 2; n++) begin
            setIn(0, 1, 14, 14, 1, 15, 1, 1, 0);
            settle();
            check("rst.stall", int'(stallA) + int'(stallB), 0);
            check("rst.bubble", int'(bubbleA) + int'(bubbleB), 0);
            check("rst.ex_hold", int'(exHoldA) + int'(exHoldB), 0);
            check("rst.issued", int'(issuedA) + int'(issuedB), 0);
            advance();
        end
        setIn(1, 1, 14, 0, 0, 15, 1, 0, 0);
        settle();
        check("rst.after.stall_count", int'(scA), 0);
        check("rst.after.err32", int'(errA), 0);
        check("rst.after.err4", int'(errB), 0);
        check("rst.after.issued", int'(issuedA), 1);
        check("rst.after.stall", int'(stallA), 0);
        advance();

        // Timeout on the TIMEOUT=4 instance: four wait cycles, then forced exit.
        for (int n = 0; n < 3; n++) begin
            setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        setIn(1, 1, 1, 2, 0, 16, 1, 1, 0);
        settle();
        check("to.issue", int'(issuedB), 1);
        advance();
        for (int n = 1; n <= 4; n++) begin
            setIn(1, 1, 1, 2, 0, 17, 1, 0, 0);
            settle();
            check($sformatf("to.w%0d.stall", n), int'(stallB), 1);
            check($sformatf("to.w%0d.err", n),   int'(errB),   0);
            advance();
        end
        settle();
        check("to.exit.stall", int'(stallB), 0);
        check("to.exit.issued", int'(issuedB), 1);
        check("to.exit.err", int'(errB), 1);
        advance();
        for (int n = 0; n < 2; n++) begin
            setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            check("to.sticky", int'(errB), 1);
            advance();
        end
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Random traffic over a small register window to provoke frequent dependences.
        for (int n = 0; n < 3000; n++) begin
            setIn($urandom_range(0, 149) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
